pe_input_feeder: RTL and testbench

//  Transmitter end of the PE Input rdy/ack stream; the PE datapath controller is the receiver.
//  - Fetches one input-row tile from the global input buffer (GIB) over a fixed-latency read port.
//  - Sends the words to the PE in the PE's loop order: channel innermost, row pixel outer.
//  - A 2-entry skid buffer keeps 1 word/cycle throughput under receiver back-pressure.

---
 rtl/pe_input_feeder_if.sv | 30 +++
 rtl/pe_input_feeder.sv | 204 ++++++++++++++++++++
 tb/tb_pe_input_feeder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_input_feeder_if.sv
// ---------------------------------------------------------------------------
// pe_input_feeder_if
//   Bus bundle between the input feeder, the global input buffer (GIB) read
//   port and the PE Input rdy/ack stream.
//   GIB read port : o_mem_req / o_mem_addr (feeder -> GIB),
//                   i_mem_rdata (GIB -> feeder, valid 1 cycle after o_mem_req)
//   PE stream     : Input_rdy / Input_dat (feeder -> PE), Input_ack (PE -> feeder)
//   master modport is the feeder side, slave is the environment side.
// ---------------------------------------------------------------------------
interface pe_input_feeder_if #(
  parameter int DATAWD = 16,
  parameter int ADDRWD = 12
) ();
  logic              o_mem_req;
  logic [ADDRWD-1:0] o_mem_addr;
  logic [DATAWD-1:0] i_mem_rdata;
  logic              Input_rdy;
  logic              Input_ack;
  logic [DATAWD-1:0] Input_dat;

  modport master (
    output o_mem_req, o_mem_addr, Input_rdy, Input_dat,
    input  i_mem_rdata, Input_ack
  );

  modport slave (
    input  o_mem_req, o_mem_addr, Input_rdy, Input_dat,
    output i_mem_rdata, Input_ack
  );
endinterface

// File: rtl/pe_input_feeder.sv
// ---------------------------------------------------------------------------
// pe_input_feeder
//   Fetches one input-row tile from the GIB and streams it to the PE with
//   channel innermost, pixel outer. A 2-entry buffer behind a credit-based
//   read issuer keeps one word per cycle flowing under back-pressure.
// Ports
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_start          pulse: latch config and start a tile (IDLE only)
//   i_clear          abort tile, flush to IDLE next cycle
//   i_Pch            channels per pixel
//   i_row_tile       pixels in the tile
//   i_base_addr      GIB address of pixel 0 / channel 0
//   i_pix_stride     GIB address step between pixels
//   bus (master)     GIB read port + PE Input rdy/ack stream
//   o_busy           high in RUN or DRAIN
//   o_done           one-cycle pulse after the last accepted word
// ---------------------------------------------------------------------------
module pe_input_feeder #(
  parameter int DATAWD = 16,
  parameter int ADDRWD = 12,
  parameter int PCHWD  = 4,
  parameter int ROWWD  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_clear,
  input  logic [PCHWD-1:0]          i_Pch,
  input  logic [ROWWD-1:0]          i_row_tile,
  input  logic [ADDRWD-1:0]         i_base_addr,
  input  logic [ADDRWD-1:0]         i_pix_stride,
  pe_input_feeder_if.master         bus,
  output logic                      o_busy,
  output logic                      o_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Latched tile configuration
  logic [PCHWD-1:0]  pch_q;
  logic [ROWWD-1:0]  row_q;
  logic [ADDRWD-1:0] stride_q;

  // Address walk: pix_base_q tracks base + pix*stride incrementally
  logic [PCHWD-1:0]  ch_q;
  logic [ROWWD-1:0]  pix_q;
  logic [ADDRWD-1:0] pix_base_q;

  // Read return tracking and 2-entry buffer (head drives Input_dat)
  logic              inflight_q;
  logic [DATAWD-1:0] head_q, head_d;
  logic              head_vld_q, head_vld_d;
  logic [DATAWD-1:0] tail_q, tail_d;
  logic              tail_vld_q, tail_vld_d;

  // Zero-length tiles spend one extra cycle in DONE so o_done lands at the
  // same point a two-stage fetch would report completion.
  logic              zero_wait_q;

  logic              mem_req;
  logic              pop;
  logic              last_rd;
  logic              cfg_zero;
  logic              start_acc;
  logic [1:0]        occ_eff;

  assign pop       = head_vld_q & bus.Input_ack;
  assign last_rd   = (ch_q == (pch_q - PCHWD'(1))) && (pix_q == (row_q - ROWWD'(1)));
  assign cfg_zero  = (i_Pch == '0) || (i_row_tile == '0);
  assign start_acc = (state_q == IDLE) && i_start && !i_clear;

  // A word popped this cycle frees its slot for a read issued this cycle;
  // its data lands one cycle later, so the buffer can never exceed 2.
  assign occ_eff = 2'(head_vld_q) + 2'(tail_vld_q) + 2'(inflight_q) - 2'(pop);

  // ---- FSM state register ----
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- FSM next state / read issue ----
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = cfg_zero ? DONE : RUN;
      end
      RUN: begin
        mem_req = (occ_eff < 2'd2);
        if (mem_req && last_rd) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && !tail_vld_q && !inflight_q) state_d = DONE;
      end
      DONE: begin
        if (!zero_wait_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_clear) begin
      state_d = IDLE;
      mem_req = 1'b0;
    end
  end

  // ---- Control registers ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      zero_wait_q <= 1'b0;
      inflight_q  <= 1'b0;
      ch_q        <= '0;
      pix_q       <= '0;
    end else begin
      inflight_q <= mem_req;
      if (i_clear)                          zero_wait_q <= 1'b0;
      else if (start_acc && cfg_zero)       zero_wait_q <= 1'b1;
      else if (state_q == DONE)             zero_wait_q <= 1'b0;
      if (start_acc) begin
        ch_q  <= '0;
        pix_q <= '0;
      end else if (mem_req) begin
        if (ch_q == (pch_q - PCHWD'(1))) begin
          ch_q  <= '0;
          pix_q <= pix_q + ROWWD'(1);
        end else begin
          ch_q  <= ch_q + PCHWD'(1);
        end
      end
    end
  end

  // ---- Configuration and address datapath ----
  always_ff @(posedge i_clk) begin
    if (start_acc) begin
      pch_q      <= i_Pch;
      row_q      <= i_row_tile;
      stride_q   <= i_pix_stride;
      pix_base_q <= i_base_addr;
    end else if (mem_req && (ch_q == (pch_q - PCHWD'(1)))) begin
      pix_base_q <= pix_base_q + stride_q;
    end
  end

  // ---- Buffer next state: pop shifts tail to head, returning data appends ----
  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    tail_d     = tail_q;
    tail_vld_d = tail_vld_q;
    if (pop) begin
      if (tail_vld_q) head_d = tail_q;
      head_vld_d = tail_vld_q;
      tail_vld_d = 1'b0;
    end
    if (inflight_q) begin
      if (!head_vld_d) begin
        head_d     = bus.i_mem_rdata;
        head_vld_d = 1'b1;
      end else begin
        tail_d     = bus.i_mem_rdata;
        tail_vld_d = 1'b1;
      end
    end
  end

  // ---- Buffer registers; clear drops valid flags so in-flight data is lost ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      head_q <= head_d;
      if (i_clear) begin
        head_vld_q <= 1'b0;
        tail_vld_q <= 1'b0;
      end else begin
        head_vld_q <= head_vld_d;
        tail_vld_q <= tail_vld_d;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    tail_q <= tail_d;
  end

  assign bus.o_mem_req  = mem_req;
  assign bus.o_mem_addr = mem_req ? (pix_base_q + ADDRWD'(ch_q)) : '0;
  assign bus.Input_rdy  = head_vld_q;
  assign bus.Input_dat  = head_q;
  assign o_busy         = (state_q == RUN) || (state_q == DRAIN);
  assign o_done         = (state_q == DONE) && !zero_wait_q;

endmodule

// File: tb/tb_pe_input_feeder.sv
module tb_pe_input_feeder;
  localparam int DATAWD = 16;
  localparam int ADDRWD = 12;
  localparam int PCHWD  = 4;
  localparam int ROWWD  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic              clear;
  logic [PCHWD-1:0]  pch;
  logic [ROWWD-1:0]  row_tile;
  logic [ADDRWD-1:0] base_addr;
  logic [ADDRWD-1:0] pix_stride;
  logic              busy;
  logic              done;

  pe_input_feeder_if #(.DATAWD(DATAWD), .ADDRWD(ADDRWD)) bus ();

  pe_input_feeder #(.DATAWD(DATAWD), .ADDRWD(ADDRWD), .PCHWD(PCHWD), .ROWWD(ROWWD)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_clear      (clear),
    .i_Pch        (pch),
    .i_row_tile   (row_tile),
    .i_base_addr  (base_addr),
    .i_pix_stride (pix_stride),
    .bus          (bus),
    .o_busy       (busy),
    .o_done       (done)
  );

  // GIB model: fixed one-cycle read latency, content derived from address
  always @(posedge clk) bus.i_mem_rdata <= {4'hA, bus.o_mem_addr};

  function automatic logic [DATAWD-1:0] word_of(input logic [ADDRWD-1:0] a);
    return {4'hA, a};
  endfunction

  function automatic logic [ADDRWD-1:0] exp_addr(input int k, input int p, input int b, input int s);
    int pix;
    int ch;
    pix = k / p;
    ch  = k % p;
    return ADDRWD'(b + pix * s + ch);
  endfunction

  int checks = 0;
  int errors = 0;

  // Observations collected by run_tile
  logic [ADDRWD-1:0] req_q[$];
  logic [DATAWD-1:0] word_q[$];
  int first_req, first_rdy, last_hs, done_cyc, busy_cnt;
  int unstable, credit_bad, rdy_bad, timed_out;

  task automatic run_tile(input int p, input int r, input int b, input int s,
                          input int ackpct, input int restart_at, input int maxcyc);
    int c;
    int occ_m;
    int inf_m;
    int hs;
    logic prev_rdy, prev_ack;
    logic [DATAWD-1:0] prev_dat;
    req_q.delete();
    word_q.delete();
    first_req = -1; first_rdy = -1; last_hs = -1; done_cyc = -1; busy_cnt = 0;
    unstable = 0; credit_bad = 0; rdy_bad = 0; timed_out = 0;
    occ_m = 0; inf_m = 0; prev_rdy = 1'b0; prev_ack = 1'b0; prev_dat = '0;
    pch = PCHWD'(p); row_tile = ROWWD'(r); base_addr = ADDRWD'(b); pix_stride = ADDRWD'(s);
    start = 1'b1;
    bus.Input_ack = ($urandom_range(0, 99) < ackpct);
    c = 0;
    forever begin
      @(negedge clk);
      hs = (bus.Input_rdy && bus.Input_ack) ? 1 : 0;
      if (bus.o_mem_req) begin
        req_q.push_back(bus.o_mem_addr);
        if (first_req < 0) first_req = c;
        if (occ_m + inf_m - hs >= 2) credit_bad++;
      end
      if (bus.Input_rdy !== (occ_m != 0)) rdy_bad++;
      if (bus.Input_rdy && first_rdy < 0) first_rdy = c;
      if (prev_rdy && !prev_ack && (!bus.Input_rdy || bus.Input_dat !== prev_dat)) unstable++;
      if (hs != 0) begin
        word_q.push_back(bus.Input_dat);
        last_hs = c;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (c >= maxcyc) begin
        timed_out = 1;
        break;
      end
      occ_m    = occ_m + inf_m - hs;
      inf_m    = bus.o_mem_req ? 1 : 0;
      prev_rdy = bus.Input_rdy;
      prev_ack = bus.Input_ack;
      prev_dat = bus.Input_dat;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (c + 1 == restart_at) begin
        start = 1'b1;
        pch = 4'd1; row_tile = 8'd1; base_addr = 12'h300;
      end
      bus.Input_ack = ($urandom_range(0, 99) < ackpct);
      c++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    bus.Input_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear = 1'b0; bus.Input_ack = 1'b0;
    pch = '0; row_tile = '0; base_addr = '0; pix_stride = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.o_mem_req); end
    checks++; if (bus.o_mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %h want 000", bus.o_mem_addr); end
    checks++; if (bus.Input_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", bus.Input_rdy); end
    checks++; if (bus.Input_dat !== '0) begin errors++; $display("FAIL reset_dat got %h want 0000", bus.Input_dat); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int n;
    run_tile(3, 4, 'h10, 3, 100, -1, 100);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", timed_out); end
    checks++; if (req_q.size() != 12) begin errors++; $display("FAIL basic_reqs got %0d want 12", req_q.size()); end
    checks++; if (word_q.size() != 12) begin errors++; $display("FAIL basic_words got %0d want 12", word_q.size()); end
    n = (req_q.size() < 12) ? req_q.size() : 12;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (req_q[k] !== ADDRWD'('h10 + k)) begin errors++; $display("FAIL basic_addr[%0d] got %h want %h", k, req_q[k], ADDRWD'('h10 + k)); end
    end
    n = (word_q.size() < 12) ? word_q.size() : 12;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (word_q[k] !== word_of(ADDRWD'('h10 + k))) begin errors++; $display("FAIL basic_word[%0d] got %h want %h", k, word_q[k], word_of(ADDRWD'('h10 + k))); end
    end
    checks++; if (first_req != 1) begin errors++; $display("FAIL basic_first_req got %0d want 1", first_req); end
    checks++; if (first_rdy != 3) begin errors++; $display("FAIL basic_first_rdy got %0d want 3", first_rdy); end
    checks++; if (last_hs != 14) begin errors++; $display("FAIL basic_last_hs got %0d want 14", last_hs); end
    checks++; if (done_cyc != 15) begin errors++; $display("FAIL basic_done_cyc got %0d want 15", done_cyc); end
    checks++; if (busy_cnt != 14) begin errors++; $display("FAIL basic_busy_cycles got %0d want 14", busy_cnt); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n;
    run_tile(3, 4, 'h10, 3, 30, -1, 600);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL bp_timeout got %0d want 0", timed_out); end
    checks++; if (word_q.size() != 12) begin errors++; $display("FAIL bp_words got %0d want 12", word_q.size()); end
    n = (word_q.size() < 12) ? word_q.size() : 12;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (word_q[k] !== word_of(ADDRWD'('h10 + k))) begin errors++; $display("FAIL bp_word[%0d] got %h want %h", k, word_q[k], word_of(ADDRWD'('h10 + k))); end
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stability got %0d want 0", unstable); end
    checks++; if (credit_bad != 0) begin errors++; $display("FAIL bp_credit got %0d want 0", credit_bad); end
    checks++; if (rdy_bad != 0) begin errors++; $display("FAIL bp_rdy_vs_occupancy got %0d want 0", rdy_bad); end
    checks++; if (done_cyc != last_hs + 1) begin errors++; $display("FAIL bp_done_cyc got %0d want %0d", done_cyc, last_hs + 1); end
  endtask

  task automatic test_zero();
    run_tile(0, 4, 'h20, 1, 100, -1, 20);
    checks++; if (req_q.size() != 0 || first_rdy != -1) begin errors++; $display("FAIL zero_pch_traffic got reqs=%0d rdy_at=%0d want 0 -1", req_q.size(), first_rdy); end
    checks++; if (done_cyc != 2) begin errors++; $display("FAIL zero_pch_done got %0d want 2", done_cyc); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL zero_pch_busy got %0d want 0", busy_cnt); end
    run_tile(3, 0, 'h20, 1, 100, -1, 20);
    checks++; if (req_q.size() != 0 || first_rdy != -1) begin errors++; $display("FAIL zero_row_traffic got reqs=%0d rdy_at=%0d want 0 -1", req_q.size(), first_rdy); end
    checks++; if (done_cyc != 2) begin errors++; $display("FAIL zero_row_done got %0d want 2", done_cyc); end
  endtask

  task automatic test_clear();
    int n;
    pch = 4'd3; row_tile = 8'd4; base_addr = 12'h40; pix_stride = 12'd3;
    bus.Input_ack = 1'b0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;     // cycle 1
    @(posedge clk); #1;                   // cycle 2: second read issued
    @(posedge clk); #1; clear = 1'b1;     // cycle 3: one word buffered, one read in flight
    @(negedge clk);
    checks++; if (bus.Input_rdy !== 1'b1 || bus.Input_dat !== word_of(12'h40)) begin errors++; $display("FAIL clear_pre got rdy=%b dat=%h want 1 %h", bus.Input_rdy, bus.Input_dat, word_of(12'h40)); end
    @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    checks++; if (bus.Input_rdy !== 1'b0 || busy !== 1'b0 || bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL clear_idle got rdy=%b busy=%b req=%b want 0 0 0", bus.Input_rdy, busy, bus.o_mem_req); end
    n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.Input_rdy !== 1'b0 || done !== 1'b0) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL clear_stale got %0d busy cycles want 0", n); end
    @(posedge clk); #1;
    run_tile(3, 4, 'h40, 3, 100, -1, 100);
    checks++; if (word_q.size() != 12) begin errors++; $display("FAIL clear_restart_words got %0d want 12", word_q.size()); end
    n = (word_q.size() < 12) ? word_q.size() : 12;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (word_q[k] !== word_of(ADDRWD'('h40 + k))) begin errors++; $display("FAIL clear_restart_word[%0d] got %h want %h", k, word_q[k], word_of(ADDRWD'('h40 + k))); end
    end
  endtask

  task automatic test_wrap();
    logic [ADDRWD-1:0] ea;
    run_tile(2, 2, 'hFFE, 'h800, 100, -1, 50);
    checks++; if (req_q.size() != 4 || word_q.size() != 4) begin errors++; $display("FAIL wrap_count got reqs=%0d words=%0d want 4 4", req_q.size(), word_q.size()); end
    for (int k = 0; k < 4; k++) begin
      ea = exp_addr(k, 2, 'hFFE, 'h800);
      if (k < req_q.size()) begin
        checks++;
        if (req_q[k] !== ea) begin errors++; $display("FAIL wrap_addr[%0d] got %h want %h", k, req_q[k], ea); end
      end
      if (k < word_q.size()) begin
        checks++;
        if (word_q[k] !== word_of(ea)) begin errors++; $display("FAIL wrap_word[%0d] got %h want %h", k, word_q[k], word_of(ea)); end
      end
    end
    checks++; if (done_cyc != 7) begin errors++; $display("FAIL wrap_done_cyc got %0d want 7", done_cyc); end
  endtask

  task automatic test_start_ignored();
    int n;
    run_tile(3, 4, 'h10, 3, 100, 5, 100);
    checks++; if (word_q.size() != 12 || req_q.size() != 12) begin errors++; $display("FAIL restart_count got reqs=%0d words=%0d want 12 12", req_q.size(), word_q.size()); end
    n = (word_q.size() < 12) ? word_q.size() : 12;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (word_q[k] !== word_of(ADDRWD'('h10 + k))) begin errors++; $display("FAIL restart_word[%0d] got %h want %h", k, word_q[k], word_of(ADDRWD'('h10 + k))); end
    end
    checks++; if (done_cyc != 15) begin errors++; $display("FAIL restart_done_cyc got %0d want 15", done_cyc); end
  endtask

  task automatic test_reset_mid();
    pch = 4'd3; row_tile = 8'd4; base_addr = 12'h10; pix_stride = 12'd3;
    bus.Input_ack = 1'b0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++; if (bus.Input_rdy !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre got rdy=%b busy=%b want 1 1", bus.Input_rdy, busy); end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.Input_rdy !== 1'b0 || bus.Input_dat !== '0 || bus.o_mem_req !== 1'b0 ||
        bus.o_mem_addr !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs got rdy=%b dat=%h req=%b addr=%h busy=%b done=%b want all 0",
               bus.Input_rdy, bus.Input_dat, bus.o_mem_req, bus.o_mem_addr, busy, done);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_clear();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
